rst_ctrl_seq: RTL and testbench

- Reset sequencer for the reset controller. Generates ordered, stretched, active-low reset outputs for NUM_OUTPUTS downstream domains.
- Sits upstream of the per-domain reset synchronizers.
- On power-on reset or a runtime reset request, it asserts all outputs together. It holds them for a minimum time, then releases them one at a time in index order, with a fixed gap between releases.

---
 rtl/rst_ctrl_seq_if.sv | 26 ++
 rtl/rst_ctrl_seq.sv | 136 +++++++++++++
 tb/tb_rst_ctrl_seq.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/rst_ctrl_seq_if.sv
// Bundle of the sequencer's request input and its sequenced reset/status outputs.
// The sequencer uses the master side; whoever requests resets and watches the outputs uses the slave side.
interface rst_ctrl_seq_if #(
  parameter int NUM_OUTPUTS = 3
);

  logic                   reset_req;
  logic [NUM_OUTPUTS-1:0] reset_out_n;
  logic                   busy;
  logic                   seq_done;

  modport master (
    input  reset_req,
    output reset_out_n,
    output busy,
    output seq_done
  );

  modport slave (
    output reset_req,
    input  reset_out_n,
    input  busy,
    input  seq_done
  );

endinterface

// File: rtl/rst_ctrl_seq.sv
// Reset sequencer: asserts all downstream active-low resets together, stretches them,
// then releases them one by one in index order with a fixed gap between releases.
module rst_ctrl_seq #(
  parameter int NUM_OUTPUTS       = 3,
  parameter int MIN_ASSERT_CYCLES = 16,
  parameter int RELEASE_GAP       = 8,
  parameter int CNT_WIDTH         = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rst_ctrl_seq_if.master        bus
);

  localparam int IDX_W = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS + 1) : 1;

  localparam logic [1:0] ST_ASSERT  = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_IDLE    = 2'd2;

  localparam logic [CNT_WIDTH-1:0] ASSERT_LAST = CNT_WIDTH'(MIN_ASSERT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LAST    = CNT_WIDTH'(RELEASE_GAP - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST    = IDX_W'(NUM_OUTPUTS - 1);

  generate
    if (NUM_OUTPUTS < 1) begin : gen_bad_outputs
      $error("rst_ctrl_seq: NUM_OUTPUTS must be at least 1");
    end
    if (MIN_ASSERT_CYCLES < 1) begin : gen_bad_min
      $error("rst_ctrl_seq: MIN_ASSERT_CYCLES must be at least 1");
    end
    if (RELEASE_GAP < 1) begin : gen_bad_gap
      $error("rst_ctrl_seq: RELEASE_GAP must be at least 1");
    end
    if ((MIN_ASSERT_CYCLES - 1) >= (2 ** CNT_WIDTH) ||
        (RELEASE_GAP - 1) >= (2 ** CNT_WIDTH)) begin : gen_bad_width
      $error("rst_ctrl_seq: CNT_WIDTH too narrow for the configured cycle counts");
    end
  endgenerate

  logic [1:0]             state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q,   cnt_d;
  logic [IDX_W-1:0]       idx_q,   idx_d;
  logic [NUM_OUTPUTS-1:0] out_q,   out_d;
  logic                   busy_q,  busy_d;
  logic                   done_q,  done_d;

  // A request overrides everything; an unknown state falls back to a full re-assert.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (bus.reset_req) begin
      state_d = ST_ASSERT;
      cnt_d   = '0;
      idx_d   = '0;
      out_d   = '0;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (cnt_q == ASSERT_LAST) begin
            out_d[0] = 1'b1;
            cnt_d    = '0;
            idx_d    = IDX_W'(1);
            if (NUM_OUTPUTS == 1) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_RELEASE: begin
          if (cnt_q == GAP_LAST) begin
            for (int i = 0; i < NUM_OUTPUTS; i++) begin
              if (idx_q == IDX_W'(i)) begin
                out_d[i] = 1'b1;
              end
            end
            cnt_d = '0;
            idx_d = idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_IDLE: begin
        end

        default: begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
          idx_d   = '0;
          out_d   = '0;
          busy_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.reset_out_n = out_q;
  assign bus.busy        = busy_q;
  assign bus.seq_done    = done_q;

endmodule

// File: tb/tb_rst_ctrl_seq.sv
// Directed bench for rst_ctrl_seq: default configuration plus two parameter corners
// (single output with MIN=1, and four outputs with GAP=1) sharing one clock and rst_n.
module tb_rst_ctrl_seq;

  logic clk;
  logic rst_n;
  int   checkCount;
  int   passCount;

  rst_ctrl_seq_if #(.NUM_OUTPUTS(3)) busA ();
  rst_ctrl_seq_if #(.NUM_OUTPUTS(1)) busB ();
  rst_ctrl_seq_if #(.NUM_OUTPUTS(4)) busC ();

  rst_ctrl_seq #(
    .NUM_OUTPUTS(3), .MIN_ASSERT_CYCLES(16), .RELEASE_GAP(8), .CNT_WIDTH(8)
  ) dutA (
    .clk(clk), .rst_n(rst_n), .bus(busA)
  );

  rst_ctrl_seq #(
    .NUM_OUTPUTS(1), .MIN_ASSERT_CYCLES(1), .RELEASE_GAP(8), .CNT_WIDTH(8)
  ) dutB (
    .clk(clk), .rst_n(rst_n), .bus(busB)
  );

  rst_ctrl_seq #(
    .NUM_OUTPUTS(4), .MIN_ASSERT_CYCLES(5), .RELEASE_GAP(1), .CNT_WIDTH(8)
  ) dutC (
    .clk(clk), .rst_n(rst_n), .bus(busC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Thermometer of released bits at edge e counted from the start of a sequence.
  function automatic logic [31:0] expBits(int e, int minC, int gap, int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) begin
      if (e >= minC + i * gap) r[i] = 1'b1;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Steps edges 1..lastEdge of a sequence, checking DUT A (and the corners if asked).
  task automatic applyStimulus(input int lastEdge, input bit withCorners, input string name);
    for (int e = 1; e <= lastEdge; e++) begin
      tick();
      checkOutput($sformatf("%s_outA_e%0d", name, e), 32'(busA.reset_out_n), expBits(e, 16, 8, 3));
      checkOutput($sformatf("%s_busyA_e%0d", name, e), 32'(busA.busy), 32'(e < 32));
      checkOutput($sformatf("%s_doneA_e%0d", name, e), 32'(busA.seq_done), 32'(e == 32));
      if (withCorners) begin
        checkOutput($sformatf("%s_outB_e%0d", name, e), 32'(busB.reset_out_n), expBits(e, 1, 8, 1));
        checkOutput($sformatf("%s_doneB_e%0d", name, e), 32'(busB.seq_done), 32'(e == 1));
        checkOutput($sformatf("%s_busyB_e%0d", name, e), 32'(busB.busy), 32'(e < 1));
        checkOutput($sformatf("%s_outC_e%0d", name, e), 32'(busC.reset_out_n), expBits(e, 5, 1, 4));
        checkOutput($sformatf("%s_doneC_e%0d", name, e), 32'(busC.seq_done), 32'(e == 8));
      end
    end
  endtask

  initial begin
    checkCount     = 0;
    passCount      = 0;
    rst_n          = 1'b1;
    busA.reset_req = 1'b0;
    busB.reset_req = 1'b0;
    busC.reset_req = 1'b0;

    #2 rst_n = 1'b0;
    tick();
    tick();
    checkOutput("por_outA", 32'(busA.reset_out_n), 32'h0);
    checkOutput("por_busyA", 32'(busA.busy), 32'h1);
    checkOutput("por_doneA", 32'(busA.seq_done), 32'h0);
    checkOutput("por_outC", 32'(busC.reset_out_n), 32'h0);
    rst_n = 1'b1;
    $display("[TB] power-on sequence");
    applyStimulus(34, 1'b1, "por");

    $display("[TB] asynchronous reset from idle");
    tick();
    rst_n = 1'b0;
    #2;
    checkOutput("async_outA", 32'(busA.reset_out_n), 32'h0);
    checkOutput("async_busyA", 32'(busA.busy), 32'h1);
    checkOutput("async_outC", 32'(busC.reset_out_n), 32'h0);
    rst_n = 1'b1;
    applyStimulus(34, 1'b1, "rerun");

    $display("[TB] held request");
    busA.reset_req = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      checkOutput($sformatf("hold_outA_c%0d", k), 32'(busA.reset_out_n), 32'h0);
      checkOutput($sformatf("hold_busyA_c%0d", k), 32'(busA.busy), 32'h1);
    end
    busA.reset_req = 1'b0;
    applyStimulus(34, 1'b0, "afterhold");

    $display("[TB] request mid-release");
    busA.reset_req = 1'b1;
    tick();
    busA.reset_req = 1'b0;
    applyStimulus(24, 1'b0, "toMid");
    busA.reset_req = 1'b1;
    tick();
    busA.reset_req = 1'b0;
    checkOutput("mid_outA", 32'(busA.reset_out_n), 32'h0);
    checkOutput("mid_doneA", 32'(busA.seq_done), 32'h0);
    checkOutput("mid_busyA", 32'(busA.busy), 32'h1);
    applyStimulus(34, 1'b0, "afterMid");

    $display("[TB] request colliding with final release");
    busA.reset_req = 1'b1;
    tick();
    busA.reset_req = 1'b0;
    applyStimulus(31, 1'b0, "toColl");
    busA.reset_req = 1'b1;
    tick();
    busA.reset_req = 1'b0;
    checkOutput("coll_outA", 32'(busA.reset_out_n), 32'h0);
    checkOutput("coll_doneA", 32'(busA.seq_done), 32'h0);
    checkOutput("coll_busyA", 32'(busA.busy), 32'h1);
    applyStimulus(34, 1'b0, "afterColl");

    checkOutput("idle_outB", 32'(busB.reset_out_n), 32'h1);
    checkOutput("idle_outC", 32'(busC.reset_out_n), 32'hF);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
